// File: rtl/spoc_pp_pkg.sv
// Shared types and constants for the SpoC-64 post-processor.
package spoc_pp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_TAGH,
    S_TAG,
    S_AUTH,
    S_STAT
  } state_t;

  localparam logic [3:0]  OP_ENC         = 4'h2;
  localparam logic [3:0]  OP_DEC         = 4'h3;
  localparam logic [3:0]  HDR_TYPE_TAG   = 4'h8;
  localparam logic [31:0] STATUS_SUCCESS = 32'hE000_0000;
  localparam logic [31:0] STATUS_FAILURE = 32'hF000_0000;

  // Big-endian byte mask: valid bytes start at the MSB.
  function automatic logic [31:0] byte_mask(input logic [3:0] size);
    case (size)
      4'd0:    byte_mask = '0;
      4'd1:    byte_mask = 32'hFF00_0000;
      4'd2:    byte_mask = 32'hFFFF_0000;
      4'd3:    byte_mask = 32'hFFFF_FF00;
      default: byte_mask = '1;
    endcase
  endfunction

endpackage

// File: rtl/spoc_post_processor_if.sv
// Command, cipher-core and output stream signals of the post-processor.
interface spoc_post_processor_if;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_size;
  logic        end_of_block;
  logic        msg_auth;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;

  modport master (
    output cmd_data, cmd_valid, bdo, bdo_valid, bdo_size, end_of_block,
           msg_auth, msg_auth_valid, do_ready,
    input  cmd_ready, bdo_ready, msg_auth_ready, do_data, do_valid, do_last
  );

  modport slave (
    input  cmd_data, cmd_valid, bdo, bdo_valid, bdo_size, end_of_block,
           msg_auth, msg_auth_valid, do_ready,
    output cmd_ready, bdo_ready, msg_auth_ready, do_data, do_valid, do_last
  );
endinterface

// File: rtl/spoc_post_processor.sv
// SpoC-64 output stage: merges header, data, tag and status into one stream.
// Define PP_MASK_EN to zero the invalid trailing bytes of partial data words.
module spoc_post_processor
  import spoc_pp_pkg::*;
#(
  parameter int unsigned TAG_WORDS = 2,
  parameter int unsigned W         = 32
) (
  input logic                   clk,
  input logic                   rst,
  spoc_post_processor_if.slave  bus
);

  state_t             state_q;
  logic               en_q;
  logic               dec_q;
  logic               auth_ok_q;
  logic signed [16:0] cnt_q;
  logic [7:0]         tag_cnt_q;
  logic [W-1:0]       do_data_q;
  logic               do_valid_q;
  logic               do_last_q;

  logic               can_load;
  logic               cmd_fire;
  logic               bdo_fire;
  logic               auth_fire;
  logic [3:0]         opcode;
  logic [3:0]         size_eff;
  logic signed [16:0] cnt_d;
  logic [W-1:0]       data_d;
  logic               unused_eob;

  assign unused_eob = bus.end_of_block;
  assign opcode     = bus.cmd_data[31:28];

  // en_q keeps every ready low for the first cycle out of reset.
  assign can_load           = en_q & (~do_valid_q | bus.do_ready);
  assign bus.cmd_ready      = can_load & (state_q == S_IDLE || state_q == S_HDR);
  assign bus.bdo_ready      = can_load & (state_q == S_DATA || state_q == S_TAG);
  assign bus.msg_auth_ready = can_load & (state_q == S_AUTH);
  assign cmd_fire           = bus.cmd_valid & bus.cmd_ready;
  assign bdo_fire           = bus.bdo_valid & bus.bdo_ready;
  assign auth_fire          = bus.msg_auth_valid & bus.msg_auth_ready;

  assign bus.do_data  = do_data_q;
  assign bus.do_valid = do_valid_q;
  assign bus.do_last  = do_last_q;

  always_comb begin
    size_eff = bus.bdo_size;
    if ($signed({13'b0, bus.bdo_size}) > cnt_q) size_eff = cnt_q[3:0];
    cnt_d = cnt_q - $signed({13'b0, size_eff});
`ifdef PP_MASK_EN
    data_d = bus.bdo & byte_mask(size_eff);
`else
    data_d = bus.bdo;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      dec_q      <= 1'b0;
      auth_ok_q  <= 1'b0;
      cnt_q      <= '0;
      tag_cnt_q  <= '0;
      do_data_q  <= '0;
      do_valid_q <= 1'b0;
      do_last_q  <= 1'b0;
    end else begin
      en_q <= 1'b1;
      if (do_valid_q && bus.do_ready) begin
        do_valid_q <= 1'b0;
        do_last_q  <= 1'b0;
      end
      case (state_q)
        S_IDLE: if (cmd_fire && (opcode == OP_ENC || opcode == OP_DEC)) begin
          dec_q   <= (opcode == OP_DEC);
          state_q <= S_HDR;
        end
        S_HDR: if (cmd_fire) begin
          do_data_q  <= bus.cmd_data;
          do_valid_q <= 1'b1;
          do_last_q  <= 1'b0;
          cnt_q      <= $signed({1'b0, bus.cmd_data[15:0]});
          tag_cnt_q  <= '0;
          if (bus.cmd_data[15:0] == 16'h0) state_q <= dec_q ? S_AUTH : S_TAGH;
          else                             state_q <= S_DATA;
        end
        S_DATA: if (bdo_fire) begin
          do_data_q  <= data_d;
          do_valid_q <= 1'b1;
          do_last_q  <= 1'b0;
          cnt_q      <= cnt_d;
          if (cnt_d <= 17'sd0) state_q <= dec_q ? S_AUTH : S_TAGH;
        end
        S_TAGH: if (can_load) begin
          do_data_q  <= {HDR_TYPE_TAG, 4'h3, 8'h00, 16'(TAG_WORDS * 4)};
          do_valid_q <= 1'b1;
          do_last_q  <= 1'b0;
          state_q    <= S_TAG;
        end
        S_TAG: if (bdo_fire) begin
          do_data_q  <= bus.bdo;
          do_valid_q <= 1'b1;
          do_last_q  <= 1'b0;
          if (tag_cnt_q == 8'(TAG_WORDS - 1)) begin
            auth_ok_q <= 1'b1;
            state_q   <= S_STAT;
          end else begin
            tag_cnt_q <= tag_cnt_q + 8'd1;
          end
        end
        S_AUTH: if (auth_fire) begin
          auth_ok_q <= bus.msg_auth;
          state_q   <= S_STAT;
        end
        S_STAT: if (can_load) begin
          do_data_q  <= auth_ok_q ? STATUS_SUCCESS : STATUS_FAILURE;
          do_valid_q <= 1'b1;
          do_last_q  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spoc_post_processor.sv
// Directed bench for spoc_post_processor; expectations follow PP_MASK_EN.
module tb_spoc_post_processor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  int unsigned c0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];
  logic        bdo_rdy_seen = 1'b0;

  spoc_post_processor_if bus();

  spoc_post_processor #(.TAG_WORDS(2), .W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.do_valid && bus.do_ready) got_q.push_back({bus.do_last, bus.do_data});
    if (bus.bdo_ready) bdo_rdy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic last);
    exp_q.push_back({last, w});
  endtask

  task automatic check_out(input string tag);
    int unsigned k = 0;
    while (got_q.size() < exp_q.size() && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 33'(got_q.size()), 33'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_cmd(input logic [31:0] w);
    bit ok = 1'b0;
    bus.cmd_data  = w;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 33'(ok), 33'd1);
  endtask

  task automatic send_bdo(input logic [31:0] w, input logic [3:0] size);
    bit ok = 1'b0;
    bus.bdo       = w;
    bus.bdo_size  = size;
    bus.bdo_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.bdo_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bus.bdo_valid = 1'b0;
    chk("bdo_accept", 33'(ok), 33'd1);
  endtask

  task automatic send_auth(input logic a);
    bit ok = 1'b0;
    bus.msg_auth       = a;
    bus.msg_auth_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.msg_auth_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    bus.msg_auth_valid = 1'b0;
    chk("auth_accept", 33'(ok), 33'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_do_data"},  33'(bus.do_data), 33'd0);
    chk({tag, "_do_valid"}, 33'(bus.do_valid), 33'd0);
    chk({tag, "_do_last"},  33'(bus.do_last), 33'd0);
    chk({tag, "_cmd_rdy"},  33'(bus.cmd_ready), 33'd0);
    chk({tag, "_bdo_rdy"},  33'(bus.bdo_ready), 33'd0);
    chk({tag, "_auth_rdy"}, 33'(bus.msg_auth_ready), 33'd0);
  endtask

  task automatic enc8_op(input string tag);
    push_exp(32'h4000_0008, 1'b0);
    push_exp(32'hAABB_CCDD, 1'b0);
    push_exp(32'h1122_3344, 1'b0);
    push_exp(32'h8300_0008, 1'b0);
    push_exp(32'hDEAD_BEEF, 1'b0);
    push_exp(32'h0BAD_F00D, 1'b0);
    push_exp(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0008);
    send_bdo(32'hAABB_CCDD, 4'd4);
    send_bdo(32'h1122_3344, 4'd4);
    send_bdo(32'hDEAD_BEEF, 4'd4);
    send_bdo(32'h0BAD_F00D, 4'd4);
    check_out(tag);
  endtask

  initial begin
    bus.cmd_data       = '0;
    bus.cmd_valid      = 1'b0;
    bus.bdo            = '0;
    bus.bdo_valid      = 1'b0;
    bus.bdo_size       = 4'd4;
    bus.end_of_block   = 1'b0;
    bus.msg_auth       = 1'b0;
    bus.msg_auth_valid = 1'b0;
    bus.do_ready       = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    enc8_op("enc8");

    // ENC length 6 with a partial final word
    push_exp(32'h4000_0006, 1'b0);
    push_exp(32'h0102_0304, 1'b0);
`ifdef PP_MASK_EN
    push_exp(32'h5566_0000, 1'b0);
`else
    push_exp(32'h5566_7788, 1'b0);
`endif
    push_exp(32'h8300_0008, 1'b0);
    push_exp(32'hA1A2_A3A4, 1'b0);
    push_exp(32'hB1B2_B3B4, 1'b0);
    push_exp(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0006);
    send_bdo(32'h0102_0304, 4'd4);
    send_bdo(32'h5566_7788, 4'd2);
    send_bdo(32'hA1A2_A3A4, 4'd1);
    send_bdo(32'hB1B2_B3B4, 4'd3);
    check_out("enc6");

    // DEC length 0, tag mismatch; bdo offered but must never be taken
    bus.bdo       = 32'h1357_9BDF;
    bus.bdo_valid = 1'b1;
    bdo_rdy_seen  = 1'b0;
    push_exp(32'h4000_0000, 1'b0);
    push_exp(32'hF000_0000, 1'b1);
    send_cmd(32'h3000_0000);
    send_cmd(32'h4000_0000);
    send_auth(1'b0);
    check_out("dec0");
    chk("dec0_bdo_ready_seen", 33'(bdo_rdy_seen), 33'd0);
    bus.bdo_valid = 1'b0;

    // DEC length 3 fed a 4-byte word (clamped), tag match
    push_exp(32'h4000_0003, 1'b0);
`ifdef PP_MASK_EN
    push_exp(32'hCAFE_BA00, 1'b0);
`else
    push_exp(32'hCAFE_BABE, 1'b0);
`endif
    push_exp(32'hE000_0000, 1'b1);
    send_cmd(32'h3000_0000);
    send_cmd(32'h4000_0003);
    send_bdo(32'hCAFE_BABE, 4'd4);
    send_auth(1'b1);
    check_out("dec3");

    // Downstream stall mid-data, then back-to-back words
    push_exp(32'h4000_0010, 1'b0);
    push_exp(32'h1010_1010, 1'b0);
    push_exp(32'h2020_2020, 1'b0);
    push_exp(32'h3030_3030, 1'b0);
    push_exp(32'h4040_4040, 1'b0);
    push_exp(32'h8300_0008, 1'b0);
    push_exp(32'h7777_0000, 1'b0);
    push_exp(32'h7777_0001, 1'b0);
    push_exp(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0010);
    send_bdo(32'h1010_1010, 4'd4);
    bus.bdo       = 32'h2020_2020;
    bus.bdo_valid = 1'b1;
    bus.do_ready  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_do_data", 33'(bus.do_data), 33'h1010_1010);
      chk("stall_bdo_ready", 33'(bus.bdo_ready), 33'd0);
    end
    @(posedge clk);
    #1;
    bus.do_ready = 1'b1;
    c0 = cyc;
    send_bdo(32'h2020_2020, 4'd4);
    send_bdo(32'h3030_3030, 4'd4);
    send_bdo(32'h4040_4040, 4'd4);
    chk("b2b_cycles", 33'(cyc - c0), 33'd3);
    send_bdo(32'h7777_0000, 4'd4);
    send_bdo(32'h7777_0001, 4'd4);
    check_out("stall");

    // Invalid opcode is dropped, then a normal ENC op
    send_cmd(32'h7000_0000);
    repeat (5) @(posedge clk);
    #1;
    chk("inv_no_output", 33'(got_q.size()), 33'd0);
    chk("inv_do_valid", 33'(bus.do_valid), 33'd0);
    push_exp(32'h4000_0004, 1'b0);
    push_exp(32'h9988_7766, 1'b0);
    push_exp(32'h8300_0008, 1'b0);
    push_exp(32'h5A5A_5A5A, 1'b0);
    push_exp(32'hA5A5_A5A5, 1'b0);
    push_exp(32'hE000_0000, 1'b1);
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0004);
    send_bdo(32'h9988_7766, 4'd4);
    send_bdo(32'h5A5A_5A5A, 4'd4);
    send_bdo(32'hA5A5_A5A5, 4'd4);
    check_out("after_inv");

    // Reset while in S_TAG abandons the operation
    send_cmd(32'h2000_0000);
    send_cmd(32'h4000_0004);
    send_bdo(32'h1234_5678, 4'd4);
    send_bdo(32'hDEAD_BEEF, 4'd4);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    got_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_status", 33'(got_q.size()), 33'd0);
    enc8_op("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
